// File: rtl/sync_filter_bank.sv
// Multi-channel synchroniser bank: N-flop metastability chain, consecutive-sample glitch filter, rise/fall strobes.
// Optional per-channel saturating glitch counters are enabled by defining SYNC_GLITCH_COUNT_EN.

module sync_filter_ch #(
    parameter int   STAGES     = 2,
    parameter int   FILTER_LEN = 1,
    parameter logic RST_BIT    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din_i,
`ifdef SYNC_GLITCH_COUNT_EN
    input  logic       glitch_clr_i,
    output logic [7:0] glitch_count_o,
`endif
    output logic       sync_o,
    output logic       rise_o,
    output logic       fall_o
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic [STAGES-1:0] chain_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              s;

    assign s = chain_q[STAGES-1];

    // cnt counts consecutive synced samples that disagree with the output
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            out_d  = s;
            cnt_d  = '0;
            rise_d = s;
            fall_d = ~s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= {STAGES{RST_BIT}};
            cnt_q   <= '0;
            out_q   <= RST_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], din_i};
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sync_o = out_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

`ifdef SYNC_GLITCH_COUNT_EN
    logic [7:0] gcnt_q, gcnt_d;
    logic       glitch;

    // a disagreeing run that ends before qualifying is a rejected glitch
    assign glitch = (s == out_q) && (cnt_q != '0);

    always_comb begin
        gcnt_d = gcnt_q;
        if (glitch_clr_i)
            gcnt_d = 8'd0;
        else if (glitch && gcnt_q != 8'hFF)
            gcnt_d = gcnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            gcnt_q <= 8'd0;
        else
            gcnt_q <= gcnt_d;
    end

    assign glitch_count_o = gcnt_q;
`endif
endmodule

module sync_filter_bank #(
    parameter int                  CHANNELS   = 4,
    parameter int                  STAGES     = 2,
    parameter int                  FILTER_LEN = 1,
    parameter logic [CHANNELS-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   async_in,
`ifdef SYNC_GLITCH_COUNT_EN
    input  logic                  glitch_clr,
    output logic [CHANNELS*8-1:0] glitch_count,
`endif
    output logic [CHANNELS-1:0]   sync_out,
    output logic [CHANNELS-1:0]   rise,
    output logic [CHANNELS-1:0]   fall
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sync_filter_ch #(
            .STAGES    (STAGES),
            .FILTER_LEN(FILTER_LEN),
            .RST_BIT   (RESET_VAL[i])
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .din_i         (async_in[i]),
`ifdef SYNC_GLITCH_COUNT_EN
            .glitch_clr_i  (glitch_clr),
            .glitch_count_o(glitch_count[8*i +: 8]),
`endif
            .sync_o        (sync_out[i]),
            .rise_o        (rise[i]),
            .fall_o        (fall[i])
        );
    end
endmodule

// File: tb/tb_sync_filter_bank.sv
// Bench for sync_filter_bank: three configurations share stimulus and are checked every cycle
// against a delay-line / sample-window reference model, plus directed boundary checks.

module tb_sync_filter_bank;
    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       glitch_clr;
    logic [3:0] async_in;

    logic [3:0]  dso [NI];
    logic [3:0]  dri [NI];
    logic [3:0]  dfa [NI];
    logic [31:0] dgc [NI];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // u0: legacy equivalent, u1: deep filter with non-zero reset level, u2: short filter
    sync_filter_bank #(.CHANNELS(4), .STAGES(2), .FILTER_LEN(1), .RESET_VAL(4'b0000)) u0 (
        .clk(clk), .reset(reset), .async_in(async_in),
`ifdef SYNC_GLITCH_COUNT_EN
        .glitch_clr(glitch_clr), .glitch_count(dgc[0]),
`endif
        .sync_out(dso[0]), .rise(dri[0]), .fall(dfa[0]));

    sync_filter_bank #(.CHANNELS(4), .STAGES(3), .FILTER_LEN(4), .RESET_VAL(4'b1000)) u1 (
        .clk(clk), .reset(reset), .async_in(async_in),
`ifdef SYNC_GLITCH_COUNT_EN
        .glitch_clr(glitch_clr), .glitch_count(dgc[1]),
`endif
        .sync_out(dso[1]), .rise(dri[1]), .fall(dfa[1]));

    sync_filter_bank #(.CHANNELS(4), .STAGES(2), .FILTER_LEN(2), .RESET_VAL(4'b0000)) u2 (
        .clk(clk), .reset(reset), .async_in(async_in),
`ifdef SYNC_GLITCH_COUNT_EN
        .glitch_clr(glitch_clr), .glitch_count(dgc[2]),
`endif
        .sync_out(dso[2]), .rise(dri[2]), .fall(dfa[2]));

    function automatic int st_of(int j);
        case (j) 0: return 2; 1: return 3; default: return 2; endcase
    endfunction
    function automatic int fl_of(int j);
        case (j) 0: return 1; 1: return 4; default: return 2; endcase
    endfunction
    function automatic logic [3:0] rv_of(int j);
        case (j) 1: return 4'b1000; default: return 4'b0000; endcase
    endfunction

    // Reference model: inputs seen at every edge, last reset edge, per-channel last event edge
    logic [3:0]  ain_hist [0:8191];
    int          t = 0;
    int          rst_edge = -1;
    logic [3:0]  eo [NI];
    logic [3:0]  er [NI];
    logic [3:0]  ef [NI];
    logic [31:0] egc [NI];
    int          last_evt [NI][4];

    // synced sample used at edge tt: input from STAGES edges earlier, or the reset level
    function automatic logic s_at(int j, int c, int tt);
        logic [3:0] v;
        if (tt - st_of(j) > rst_edge) v = ain_hist[tt - st_of(j)];
        else v = rv_of(j);
        return v[c];
    endfunction

    task automatic model_edge();
        logic s;
        logic cur;
        bit   all_diff;
        bit   glitch;
        if (reset) begin
            rst_edge = t;
            for (int j = 0; j < NI; j++) begin
                eo[j] = rv_of(j); er[j] = 4'b0; ef[j] = 4'b0; egc[j] = 32'd0;
                for (int c = 0; c < 4; c++) last_evt[j][c] = t;
            end
        end else begin
            for (int j = 0; j < NI; j++) begin
                er[j] = 4'b0; ef[j] = 4'b0;
                for (int c = 0; c < 4; c++) begin
                    s = s_at(j, c, t);
                    cur = eo[j][c];
                    glitch = 1'b0;
                    if (s == cur) begin
                        glitch = (t - 1 > last_evt[j][c]) && (s_at(j, c, t - 1) != cur);
                    end else if (t - last_evt[j][c] >= fl_of(j)) begin
                        all_diff = 1'b1;
                        for (int k = 0; k < fl_of(j); k++)
                            if (s_at(j, c, t - k) == cur) all_diff = 1'b0;
                        if (all_diff) begin
                            eo[j][c] = s; er[j][c] = s; ef[j][c] = ~s;
                            last_evt[j][c] = t;
                        end
                    end
                    if (glitch_clr) egc[j][8*c +: 8] = 8'd0;
                    else if (glitch && egc[j][8*c +: 8] != 8'd255)
                        egc[j][8*c +: 8] = egc[j][8*c +: 8] + 8'd1;
                end
            end
        end
        ain_hist[t] = async_in;
        t++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int j = 0; j < NI; j++) begin
            nvec++;
            assert ({dso[j], dri[j], dfa[j]} === {eo[j], er[j], ef[j]}) else begin
                nerr++;
                $error("FAIL model_u%0d edge=%0d out/rise/fall got %b/%b/%b want %b/%b/%b",
                       j, t - 1, dso[j], dri[j], dfa[j], eo[j], er[j], ef[j]);
            end
`ifdef SYNC_GLITCH_COUNT_EN
            nvec++;
            assert (dgc[j] === egc[j]) else begin
                nerr++;
                $error("FAIL model_gc_u%0d edge=%0d got %h want %h", j, t - 1, dgc[j], egc[j]);
            end
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; async_in = 4'b0; glitch_clr = 1'b0;

        // reset level 4'b1000 held two cycles, then ch3 falls STAGES+FILTER_LEN edges after release
        step(); chk("rst_out", {28'b0, dso[1]}, 32'h8);
        step(); chk("rst_out2", {28'b0, dso[1]}, 32'h8);
        chk("rst_strobe", {24'b0, dri[1], dfa[1]}, 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k < 7) begin
                chk("rel_hold", {28'b0, dso[1]}, 32'h8);
                chk("rel_nostrobe", {24'b0, dri[1], dfa[1]}, 32'h0);
            end else begin
                chk("rel_fall", {24'b0, dri[1], dfa[1]}, 32'h08);
                chk("rel_out", {28'b0, dso[1]}, 32'h0);
            end
        end

        // 3-cycle pulse is filtered out by FILTER_LEN=4
        step(); step();
        async_in = 4'b0001;
        step(); step(); step();
        async_in = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("pulse3_out", {31'b0, dso[1][0]}, 32'h0);
            chk("pulse3_rise", {31'b0, dri[1][0]}, 32'h0);
        end
`ifdef SYNC_GLITCH_COUNT_EN
        chk("pulse3_gc", {24'b0, dgc[1][7:0]}, 32'h1);
`endif

        // 4-cycle pulse qualifies, appears after edge 7
        async_in = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 4) async_in = 4'b0000;
            if (k < 7) chk("pulse4_wait", {31'b0, dso[1][0]}, 32'h0);
            else begin
                chk("pulse4_out", {31'b0, dso[1][0]}, 32'h1);
                chk("pulse4_rise", {28'b0, dri[1]}, 32'h1);
            end
        end
        for (int k = 0; k < 8; k++) step();

        // reset while ch1 filter count is 2
        async_in = 4'b0010;
        for (int k = 0; k < 5; k++) step();
        reset = 1'b1;
        step();
        chk("midrst_out", {28'b0, dso[1]}, 32'h8);
        chk("midrst_strobe", {24'b0, dri[1], dfa[1]}, 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k < 7) chk("midrst_wait", {28'b0, dri[1]}, 32'h0);
            else begin
                chk("midrst_rise", {28'b0, dri[1]}, 32'h2);
                chk("midrst_fall", {28'b0, dfa[1]}, 32'h8);
            end
        end

        // legacy latency: 0 -> 4'b0101 shows after edge 3 with a single rise strobe
        async_in = 4'b0000;
        for (int k = 0; k < 10; k++) step();
        async_in = 4'b0101;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 3) chk("lat_wait", {28'b0, dso[0]}, 32'h0);
            else if (k == 3) begin
                chk("lat_out", {28'b0, dso[0]}, 32'h5);
                chk("lat_rise", {28'b0, dri[0]}, 32'h5);
                chk("lat_fall", {28'b0, dfa[0]}, 32'h0);
            end else chk("lat_rise_once", {28'b0, dri[0]}, 32'h0);
        end

        // 300 single-cycle glitches on ch2 against FILTER_LEN=2
        async_in = 4'b0000;
        for (int k = 0; k < 12; k++) step();
        for (int k = 0; k < 300; k++) begin
            async_in = 4'b0100; step();
            async_in = 4'b0000; step();
        end
        for (int k = 0; k < 4; k++) step();
        chk("toggle_hold", {31'b0, dso[2][2]}, 32'h0);
`ifdef SYNC_GLITCH_COUNT_EN
        chk("gc_sat", {24'b0, dgc[2][23:16]}, 32'hFF);
`endif
        async_in = 4'b0100; step();
        async_in = 4'b0000; step(); step();
        glitch_clr = 1'b1; step();
        glitch_clr = 1'b0;
`ifdef SYNC_GLITCH_COUNT_EN
        chk("gc_clr_wins", {24'b0, dgc[2][23:16]}, 32'h0);
`endif

        // random traffic with occasional reset and clear
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 2) == 0) async_in[c] = ~async_in[c];
            reset = ($urandom_range(0, 199) == 0);
            glitch_clr = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
